// File: rtl/elixirchip_es1_spu_divsu_pkg.sv
// Shared width helpers and default sizes for the signed/unsigned divide op.
package elixirchip_es1_spu_divsu_pkg;

    localparam int unsigned DEF_S_DATA0_BITS = 8;
    localparam int unsigned DEF_S_DATA1_BITS = 8;
    localparam int unsigned DEF_M_DATA_BITS  = 8;

    // Partial remainder carries one guard bit above the divisor width.
    function automatic int unsigned prem_bits(input int unsigned divisor_bits);
        return divisor_bits + 1;
    endfunction

    // Input register + one stage per dividend bit + output register.
    function automatic int unsigned pipe_depth(input int unsigned dividend_bits);
        return dividend_bits + 2;
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_divsu_stage.sv
// One registered restoring-division step. The dq register starts as the
// dividend magnitude and ends as the quotient: each step consumes its MSB and
// shifts the new quotient bit in at the LSB.
module elixirchip_es1_spu_op_divsu_stage
    import elixirchip_es1_spu_divsu_pkg::*;
#(
    parameter  int unsigned N  = DEF_S_DATA0_BITS,
    parameter  int unsigned D1 = DEF_S_DATA1_BITS,
    localparam int unsigned P  = prem_bits(D1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cke,
    input  logic [N-1:0]  dq_i,
    input  logic [P-1:0]  prem_i,
    input  logic [D1-1:0] div_i,
    input  logic          neg_i,
    input  logic          clr_i,
    input  logic          vld_i,
    output logic [N-1:0]  dq_o,
    output logic [P-1:0]  prem_o,
    output logic [D1-1:0] div_o,
    output logic          neg_o,
    output logic          clr_o,
    output logic          vld_o
);

    logic [N-1:0]  dq_q,   dq_d;
    logic [P-1:0]  prem_q, prem_d;
    logic [D1-1:0] div_q;
    logic          neg_q, clr_q, vld_q;
    logic [P:0]    shifted_c, diff_c;
    logic          ge_c;

    // Shift in the next dividend bit, trial-subtract, restore on borrow.
    always_comb begin
        shifted_c = {prem_i, dq_i[N-1]};
        diff_c    = shifted_c - (P+1)'(div_i);
        ge_c      = shifted_c >= (P+1)'(div_i);
        dq_d      = N'({dq_i, ge_c});
        prem_d    = ge_c ? P'(diff_c) : P'(shifted_c);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dq_q   <= '0;
            prem_q <= '0;
            div_q  <= '0;
            neg_q  <= 1'b0;
            clr_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else if (cke) begin
            dq_q   <= dq_d;
            prem_q <= prem_d;
            div_q  <= div_i;
            neg_q  <= neg_i;
            clr_q  <= clr_i;
            vld_q  <= vld_i;
        end
    end

    assign dq_o   = dq_q;
    assign prem_o = prem_q;
    assign div_o  = div_q;
    assign neg_o  = neg_q;
    assign clr_o  = clr_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/elixirchip_es1_spu_op_divsu.sv
// Fully pipelined signed-dividend / unsigned-divisor divide with fixed latency.
// Quotient truncates toward zero; remainder follows the dividend sign.
module elixirchip_es1_spu_op_divsu
    import elixirchip_es1_spu_divsu_pkg::*;
#(
    parameter int unsigned            S_DATA0_BITS = DEF_S_DATA0_BITS,
    parameter int unsigned            S_DATA1_BITS = DEF_S_DATA1_BITS,
    parameter int unsigned            LATENCY      = pipe_depth(S_DATA0_BITS),
    parameter int unsigned            M_DATA_BITS  = DEF_M_DATA_BITS,
    parameter int unsigned            M_REM_BITS   = prem_bits(S_DATA1_BITS),
    parameter logic [M_DATA_BITS-1:0] CLEAR_DATA   = '0,
    parameter logic [M_REM_BITS-1:0]  CLEAR_REM    = '0,
    parameter bit                     USE_CLEAR    = 1'b0,
    parameter bit                     USE_VALID    = 1'b0,
    parameter string                  DEVICE       = "RTL",
    parameter string                  SIMULATION   = "false",
    parameter string                  DEBUG        = "false"
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cke,
    input  logic [S_DATA0_BITS-1:0] s_data0,
    input  logic [S_DATA1_BITS-1:0] s_data1,
    input  logic                    s_clear,
    input  logic                    s_valid,
    output logic [M_DATA_BITS-1:0]  m_data,
    output logic [M_REM_BITS-1:0]   m_rem,
    output logic                    m_valid
);

    localparam int unsigned N     = S_DATA0_BITS;
    localparam int unsigned D1    = S_DATA1_BITS;
    localparam int unsigned P     = prem_bits(D1);
    localparam int unsigned DEPTH = pipe_depth(N);
    localparam int unsigned EXTRA = (LATENCY > DEPTH) ? LATENCY - DEPTH : 0;
    // A misconfigured instance never issues a valid rather than mis-scheduling.
    localparam bit CFG_OK = (LATENCY >= DEPTH) && (DEVICE != "") &&
                            (SIMULATION != "") && (DEBUG != "");

    logic          vld_in_c, clr_in_c;
    logic [N-1:0]  abs_in_c;

    logic [N-1:0]  dq0_q;
    logic [D1-1:0] div0_q;
    logic          neg0_q, clr0_q, vld0_q;

    logic [N-1:0]  dq   [0:N];
    logic [P-1:0]  prem [0:N];
    logic [D1-1:0] dv   [0:N];
    logic          neg  [0:N];
    logic          clr  [0:N];
    logic          vld  [0:N];

    always_comb begin
        vld_in_c = CFG_OK && (USE_VALID ? s_valid : 1'b1);
        clr_in_c = USE_CLEAR ? s_clear : 1'b0;
        abs_in_c = s_data0[N-1] ? N'(N'(0) - s_data0) : s_data0;
    end

    // Input register: dividend magnitude and sign, divisor, control.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dq0_q  <= '0;
            div0_q <= '0;
            neg0_q <= 1'b0;
            clr0_q <= 1'b0;
            vld0_q <= 1'b0;
        end else if (cke) begin
            dq0_q  <= abs_in_c;
            div0_q <= s_data1;
            neg0_q <= s_data0[N-1];
            clr0_q <= clr_in_c;
            vld0_q <= vld_in_c;
        end
    end

    assign dq[0]   = dq0_q;
    assign prem[0] = '0;
    assign dv[0]   = div0_q;
    assign neg[0]  = neg0_q;
    assign clr[0]  = clr0_q;
    assign vld[0]  = vld0_q;

    for (genvar i = 1; i <= N; i++) begin : g_stage
        elixirchip_es1_spu_op_divsu_stage #(
            .N  (N),
            .D1 (D1)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .cke     (cke),
            .dq_i    (dq[i-1]),
            .prem_i  (prem[i-1]),
            .div_i   (dv[i-1]),
            .neg_i   (neg[i-1]),
            .clr_i   (clr[i-1]),
            .vld_i   (vld[i-1]),
            .dq_o    (dq[i]),
            .prem_o  (prem[i]),
            .div_o   (dv[i]),
            .neg_o   (neg[i]),
            .clr_o   (clr[i]),
            .vld_o   (vld[i])
        );
    end

    logic [N:0]             q_ext_c, q_s_c;
    logic [P:0]             r_ext_c, r_s_c;
    logic                   q_neg_c;
    logic [M_DATA_BITS-1:0] q_res_c;
    logic [M_REM_BITS-1:0]  r_res_c;

    // Sign correction; a zero divisor keeps its all-ones quotient as -1.
    always_comb begin
        q_neg_c = neg[N] && (dv[N] != '0);
        q_ext_c = {1'b0, dq[N]};
        r_ext_c = {1'b0, prem[N]};
        q_s_c   = q_neg_c ? (N+1)'((N+1)'(0) - q_ext_c) : q_ext_c;
        r_s_c   = neg[N]  ? (P+1)'((P+1)'(0) - r_ext_c) : r_ext_c;
        q_res_c = M_DATA_BITS'($signed(q_s_c));
        r_res_c = M_REM_BITS'($signed(r_s_c));
    end

    logic [M_DATA_BITS-1:0] out_data_q;
    logic [M_REM_BITS-1:0]  out_rem_q;
    logic                   out_vld_q;

    // Output register: data loads only on valid so idle slots hold the last result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data_q <= '0;
            out_rem_q  <= '0;
            out_vld_q  <= 1'b0;
        end else if (cke) begin
            out_vld_q <= vld[N];
            if (vld[N]) begin
                out_data_q <= clr[N] ? CLEAR_DATA : q_res_c;
                out_rem_q  <= clr[N] ? CLEAR_REM  : r_res_c;
            end
        end
    end

    if (EXTRA == 0) begin : g_no_dly
        assign m_data  = out_data_q;
        assign m_rem   = out_rem_q;
        assign m_valid = out_vld_q;
    end else begin : g_dly
        logic [M_DATA_BITS-1:0] dly_data_q [EXTRA];
        logic [M_REM_BITS-1:0]  dly_rem_q  [EXTRA];
        logic                   dly_vld_q  [EXTRA];

        // Pass-through delay stages padding the latency out to LATENCY.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int unsigned i = 0; i < EXTRA; i++) begin
                    dly_data_q[i] <= '0;
                    dly_rem_q[i]  <= '0;
                    dly_vld_q[i]  <= 1'b0;
                end
            end else if (cke) begin
                dly_data_q[0] <= out_data_q;
                dly_rem_q[0]  <= out_rem_q;
                dly_vld_q[0]  <= out_vld_q;
                for (int unsigned i = 1; i < EXTRA; i++) begin
                    dly_data_q[i] <= dly_data_q[i-1];
                    dly_rem_q[i]  <= dly_rem_q[i-1];
                    dly_vld_q[i]  <= dly_vld_q[i-1];
                end
            end
        end

        assign m_data  = dly_data_q[EXTRA-1];
        assign m_rem   = dly_rem_q[EXTRA-1];
        assign m_valid = dly_vld_q[EXTRA-1];
    end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_divsu.sv
// Scoreboard bench for the pipelined signed/unsigned divider (8/8/8, latency 10).
module tb_elixirchip_es1_spu_op_divsu;

    localparam int unsigned LAT = 10;
    localparam logic [7:0] CLR_D = 8'h5A;
    localparam logic [8:0] CLR_R = 9'h0A5;

    logic       clk = 1'b0;
    logic       reset_n, cke, s_clear, s_valid;
    logic [7:0] s_data0, s_data1;
    logic [7:0] m_data;
    logic [8:0] m_rem;
    logic       m_valid;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_divsu #(
        .S_DATA0_BITS (8),
        .S_DATA1_BITS (8),
        .LATENCY      (LAT),
        .M_DATA_BITS  (8),
        .M_REM_BITS   (9),
        .CLEAR_DATA   (CLR_D),
        .CLEAR_REM    (CLR_R),
        .USE_CLEAR    (1'b1),
        .USE_VALID    (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cke     (cke),
        .s_data0 (s_data0),
        .s_data1 (s_data1),
        .s_clear (s_clear),
        .s_valid (s_valid),
        .m_data  (m_data),
        .m_rem   (m_rem),
        .m_valid (m_valid)
    );

    typedef struct {
        logic [7:0]  q;
        logic [8:0]  r;
        int unsigned stamp;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  cur_q = '0;
    logic [8:0]  cur_r = '0;
    logic [7:0]  hold_q = '0;
    logic [8:0]  hold_r = '0;
    int unsigned en_edges = 0;
    bit          last_en = 1'b0;
    bit          last_rst = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference divide: truncating toward zero, zero divisor gives q=-1, r=dividend.
    function automatic void model(input logic signed [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [8:0] r);
        int ia, ib;
        ia = a;
        ib = int'(b);
        if (ib == 0) begin
            q = 8'hFF;
            r = 9'(ia);
        end else begin
            q = 8'(ia / ib);
            r = 9'(ia % ib);
        end
    endfunction

    // Issue side: an op is accepted on an enabled, non-reset edge with s_valid.
    always @(posedge clk) begin
        last_en  = reset_n && cke;
        last_rst = !reset_n;
        if (!reset_n) begin
            sb.delete();
        end else if (cke) begin
            if (s_valid) sb.push_back('{cur_q, cur_r, en_edges});
            en_edges++;
        end
    end

    // Monitor: compare every new output slot against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (last_rst) begin
            chk("reset_m_data", 32'(m_data), 32'd0);
            chk("reset_m_rem", 32'(m_rem), 32'd0);
            chk("reset_m_valid", 32'(m_valid), 32'd0);
            hold_q = '0;
            hold_r = '0;
        end else if (last_en) begin
            if (m_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'(m_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", 32'(m_data), 32'(e.q));
                    chk("remainder", 32'(m_rem), 32'(e.r));
                    chk("latency", en_edges - e.stamp, LAT);
                    hold_q = e.q;
                    hold_r = e.r;
                end
            end else begin
                chk("hold_m_data", 32'(m_data), 32'(hold_q));
                chk("hold_m_rem", 32'(m_rem), 32'(hold_r));
            end
        end
    end

    task automatic drive(input bit rn, input bit k, input bit v, input bit c,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [8:0] er);
        @(posedge clk);
        #1;
        reset_n = rn; cke = k; s_valid = v; s_clear = c;
        s_data0 = a; s_data1 = b; cur_q = eq; cur_r = er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 9'd0);
    endtask

    initial begin
        logic [7:0] a, b, eq;
        logic [8:0] er;
        bit         k;
        int         issued;

        reset_n = 1'b0; cke = 1'b1; s_valid = 1'b0; s_clear = 1'b0;
        s_data0 = '0; s_data1 = '0;
        repeat (3) @(posedge clk);
        idle(2);

        // Directed corner cases, back to back.
        drive(1, 1, 1, 0, 8'd100, 8'd7,   8'h0E, 9'h002);
        drive(1, 1, 1, 0, 8'h9C,  8'd7,   8'hF2, 9'h1FE);
        drive(1, 1, 1, 0, 8'h80,  8'd1,   8'h80, 9'h000);
        drive(1, 1, 1, 0, 8'h80,  8'd255, 8'h00, 9'h180);
        drive(1, 1, 1, 0, 8'd5,   8'd0,   8'hFF, 9'h005);
        drive(1, 1, 1, 0, 8'hFB,  8'd0,   8'hFF, 9'h1FB);
        idle(3);
        drive(1, 1, 1, 1, 8'd100, 8'd7,   CLR_D, CLR_R);
        drive(1, 1, 0, 1, 8'd50,  8'd3,   8'h00, 9'h000);
        drive(1, 1, 1, 0, 8'd37,  8'd5,   8'h07, 9'h002);
        drive(1, 1, 1, 0, 8'hDB,  8'd5,   8'hF9, 9'h1FE);
        idle(14);

        // Random ops with cke stalls; stalled cycles present junk that must not be taken.
        issued = 0;
        while (issued < 20) begin
            k = ($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            model(a, b, eq, er);
            drive(1, k, 1, 0, a, b, eq, er);
            if (k) issued++;
        end
        idle(14);

        // Reset with ops in flight: none of these may ever reach the output.
        drive(1, 1, 1, 0, 8'd100, 8'd7, 8'h0E, 9'h002);
        drive(1, 1, 1, 0, 8'd9,   8'd2, 8'h04, 9'h001);
        drive(1, 1, 1, 0, 8'hF7,  8'd2, 8'hFC, 9'h1FF);
        drive(1, 1, 1, 0, 8'd1,   8'd0, 8'hFF, 9'h001);
        drive(1, 1, 1, 0, 8'd64,  8'd8, 8'h08, 9'h000);
        idle(3);
        drive(0, 1, 0, 0, 8'd0, 8'd0, 8'h00, 9'h000);
        idle(4);
        drive(1, 1, 1, 0, 8'd127, 8'd10, 8'h0C, 9'h007);
        idle(14);

        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
